// File: rtl/bash_hash_params_pkg.sv
// -----------------------------------------------------------------------------
// bash_hash_params_pkg
//   Shared constants and types for the bash-f hash controller.
//   - NROUNDS_DEFAULT : bash-f rounds per request (legal 2..31; round_o is 5 bits)
//   - state_e         : controller FSM state encoding, also driven on the
//                       controller's state_o debug output
// -----------------------------------------------------------------------------
package bash_hash_params_pkg;

    localparam int NROUNDS_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : bash_hash_params_pkg

// File: rtl/bash_hash_ctrl.sv
// -----------------------------------------------------------------------------
// bash_hash_ctrl
//   Sequencing controller for the bash_hash datapath: accepts one block per
//   request, strobes the datapath load/preset, advances NROUNDS-1 rounds and
//   then holds the result until the consumer takes it.
//
//   Ports
//     clk_i        sole clock, rising edge
//     rst_i        asynchronous active-high reset
//     req_valid_i  requester offers a block (x0..x15 and l_i valid this cycle)
//     req_ready_o  controller accepts a block this cycle
//     l_i          security level code (0=128, 1=192, 2=256)
//     abort_i      synchronous abort of the request in progress
//     start_o      datapath load strobe
//     prep_o       datapath S23 preset strobe
//     work_o       datapath round-advance strobe
//     l_o          level code to the datapath (only meaningful with start_o)
//     res_valid_o  datapath y0..y7 hold the final result
//     res_ready_i  consumer takes the result
//     busy_o       a request is in progress (RUN or DONE)
//     round_o      completed rounds for the current request
//     state_o      FSM state, debug observation only
//
//   Handshakes: a transfer happens on a rising clk_i edge when valid and ready
//   are both high in the preceding cycle; ready may depend combinationally on
//   the other side's signals only as noted (req_ready_o looks at res_ready_i
//   so a result handoff and a new accept can share one cycle), and valid,
//   once raised, is held until the transfer or an abort.
// -----------------------------------------------------------------------------
module bash_hash_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int NROUNDS = NROUNDS_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] l_i,
    input  logic       abort_i,
    output logic       start_o,
    output logic       prep_o,
    output logic       work_o,
    output logic [1:0] l_o,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic       busy_o,
    output logic [4:0] round_o,
    output logic [1:0] state_o
);

    // Value of round_o in the last RUN cycle; the edge out of it lands in
    // DONE with round_o == NROUNDS.
    localparam logic [4:0] LAST_RUN_ROUND = 5'(NROUNDS - 1);

    state_e     state_q, state_d;
    logic [4:0] round_q, round_d;
    logic       acc;

    // Outputs decode straight from the registered state, so the asynchronous
    // reset drops work_o/res_valid_o/busy_o without waiting for an edge.
    // rst_i gates ready directly because IDLE alone would otherwise look
    // ready while reset is held.
    always_comb begin
        req_ready_o = ~rst_i & ~abort_i &
                      ((state_q == ST_IDLE) | ((state_q == ST_DONE) & res_ready_i));
        acc         = req_valid_i & req_ready_o;
        start_o     = acc;
        prep_o      = acc;
        l_o         = acc ? l_i : 2'd0;
        work_o      = (state_q == ST_RUN) & ~abort_i;
        res_valid_o = (state_q == ST_DONE) & ~abort_i;
        busy_o      = (state_q != ST_IDLE);
        round_o     = round_q;
        state_o     = state_q;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            round_d = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        // The loaded datapath already shows round 1 at bash_f.
                        state_d = ST_RUN;
                        round_d = 5'd1;
                    end
                end
                ST_RUN: begin
                    // req_valid_i is deliberately not looked at here.
                    round_d = round_q + 5'd1;
                    if (round_q == LAST_RUN_ROUND) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        if (acc) begin
                            state_d = ST_RUN;
                            round_d = 5'd1;
                        end else begin
                            state_d = ST_IDLE;
                            round_d = 5'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    round_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            round_q <= 5'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

endmodule : bash_hash_ctrl

// File: doc/bash_hash_ctrl.md
BASH_HASH_CTRL -- requirements
Module: bash_hash_ctrl

Interface
REQ-001 Parameter NROUNDS, default 24, number of bash-f rounds per request; legal range 2..31.
REQ-002 clk_i  input  1  sole clock, all state updates on posedge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  requester has a block; x0..x15 and l_i are valid in the same cycle.
REQ-005 req_ready_o  output  1  controller accepts a block this cycle.
REQ-006 l_i  input  2  security level code: 0 = 128, 1 = 192, 2 = 256; 3 is reserved and never driven.
REQ-007 abort_i  input  1  synchronous abort of the request in progress.
REQ-008 start_o  output  1  datapath load strobe (start_i of bash_hash).
REQ-009 prep_o  output  1  datapath S23 preset strobe (prep_i of bash_hash).
REQ-010 work_o  output  1  datapath round-advance strobe (work_i of bash_hash).
REQ-011 l_o  output  2  level code to the datapath (l_i of bash_hash).
REQ-012 res_valid_o  output  1  y0..y7 of the datapath hold the final result.
REQ-013 res_ready_i  input  1  consumer takes the result.
REQ-014 busy_o  output  1  a request is in progress (RUN or DONE).
REQ-015 round_o  output  5  number of completed rounds for the current request.

Function
REQ-016 The FSM shall have the states IDLE, RUN and DONE.
REQ-017 The accept condition is acc = req_valid_i & req_ready_o.
REQ-018 req_ready_o = ~abort_i & (IDLE | (DONE & res_ready_i)), combinational.
REQ-019 start_o = prep_o = acc; l_o = l_i when acc, else 0.
REQ-020 On acc, the next state shall be RUN and round_o shall be 1, because the loaded state exposes round 1 at the bash_f output.
REQ-021 In RUN, work_o = ~abort_i and round_o shall increment each cycle.
REQ-022 RUN shall go to DONE when round_o == NROUNDS-1 at the clock edge, so that round_o == NROUNDS in DONE.
REQ-023 work_o shall be asserted for exactly NROUNDS-1 consecutive cycles per request.
REQ-024 Latency: for acc in cycle T, res_valid_o shall rise in cycle T+NROUNDS.
REQ-025 In DONE, res_valid_o = 1 and work_o = start_o = 0, so the datapath registers and y0..y7 are held stable.
REQ-026 In DONE, when res_ready_i = 1 and req_valid_i = 0, the next state shall be IDLE and round_o shall be 0.
REQ-027 In DONE, when res_ready_i = 1 and req_valid_i = 1, the result handoff and the new accept shall happen in the same cycle, and the next state shall be RUN.
REQ-028 When abort_i = 1 in any state, the next state shall be IDLE, round_o shall become 0, and start_o, prep_o, work_o and res_valid_o shall be 0 that cycle.
REQ-029 abort_i shall take priority over req_valid_i and res_ready_i.
REQ-030 res_valid_o shall stay asserted until res_ready_i = 1 or abort_i = 1, even while res_ready_i is low.
REQ-031 busy_o = RUN | DONE.
REQ-032 start_o and work_o shall never both be 1 in the same cycle.
REQ-033 req_valid_i shall be ignored in RUN.

Reset
REQ-034 While rst_i = 1: state = IDLE, round_o = 0, and all strobes, res_valid_o and busy_o = 0.
REQ-035 req_ready_o = 0 while rst_i = 1.
REQ-036 Reset asserted mid-RUN or in DONE shall drop work_o and res_valid_o immediately, without waiting for a clock edge.
REQ-037 The first accept shall be possible in the first cycle after rst_i deasserts.

Structure
REQ-038 NROUNDS default and the FSM state enum typedef shall live in bash_hash_params_pkg.
REQ-039 The block shall have no sub-module; it is one FSM plus a 5-bit counter.
REQ-040 The integration top shall instantiate bash_hash_ctrl beside bash_hash, with strobes wired one-to-one.

Verification
REQ-041 Single request: l_i = 2 with NIST-vector x, res_ready_i held 1 -> start_o and prep_o for 1 cycle, work_o for 23 cycles, res_valid_o at T+24, y0..y7 match the reference model.
REQ-042 Backpressure: res_ready_i = 0 for 10 cycles after DONE -> res_valid_o held high, y0..y7 constant, work_o = 0 throughout.
REQ-043 Back-to-back: second req_valid_i asserted in the DONE cycle with res_ready_i = 1 -> second start_o in that same cycle, second res_valid_o exactly 24 cycles later, both results correct.
REQ-044 Abort: abort_i at round_o = 10 -> IDLE next cycle, round_o = 0, no res_valid_o; a following request for l_i = 0 completes correctly.
REQ-045 Reset mid-RUN: rst_i pulsed at round_o = 5 -> all outputs 0 asynchronously; the first post-reset request produces the correct result at T+24.
REQ-046 Assertions over all tests: start_o and work_o are never both high; work_o-high count per request = NROUNDS-1.
